cmp_arbiter: RTL and testbench

- Shares one registered comparator unit (1-cycle latency: operands/function presented in cycle t, result valid in cycle t+1 only) among NREQ requesters, e.g. branch resolution and set-less-than paths.
- Per-requester valid/ready handshake, round-robin arbitration and requester-ID tracking across the comparator latency.
- Single-entry hold buffer absorbs response backpressure; flush input discards work on pipeline redirect.

---
 rtl/cmp_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// ============================================================================
// cmp_arbiter
// ----------------------------------------------------------------------------
// Shares one external registered comparator (operands in cycle t, result in
// cycle t+1 only) among NREQ requesters. Requesters are served round-robin
// through a valid/ready handshake. The owner of each result is tracked across
// the comparator latency. A single-entry hold buffer captures the result when
// the response consumer stalls, because the comparator does not keep it past
// t+1. A flush discards both the in-flight and the held result, and blocks
// grants in the same cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[NREQ]     per-requester request valid
//   req_ready[NREQ]     per-requester grant (one-hot or zero)
//   req_a/req_b         per-requester 32-bit operands, requester i at [32i+:32]
//   req_func            per-requester function, requester i at [3i+:3]
//                       (bit2 less, bit1 unsigned, bit0 negate)
//   flush               discard in-flight/held results, block grants
//   cmp_a/cmp_b/cmp_func  operands/function driven to the comparator
//   cmp_result          comparator result, valid the cycle after issue
//   rsp_valid/rsp_ready response handshake
//   rsp_id              index of the requester owning the response
//   rsp_result          comparison result
// ============================================================================
module cmp_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*3-1:0] req_func,
    input  logic              flush,
    output logic [31:0]       cmp_a,
    output logic [31:0]       cmp_b,
    output logic [2:0]        cmp_func,
    input  logic              cmp_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_result
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IDW-1:0] rr_ptr_q,      rr_ptr_d;
    logic           inflight_q,    inflight_d;
    logic [IDW-1:0] inflight_id_q, inflight_id_d;
    logic           hold_valid_q,  hold_valid_d;
    logic [IDW-1:0] hold_id_q,     hold_id_d;
    logic           hold_result_q, hold_result_d;

    logic           grant_en;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;

    // ------------------------------------------------------------------------
    // Round-robin arbitration.
    // The request vector is doubled and shifted right by rr_ptr+1, so that
    // bit j of the low half corresponds to requester (rr_ptr+1+j) mod NREQ.
    // The lowest set bit of that rotated view is the winner. Grants are
    // suppressed in reset so req_ready stays low while rst_n is asserted.
    // ------------------------------------------------------------------------
    always_comb begin : arb_comb
        logic [2*NREQ-1:0] dbl_valid;
        logic [NREQ-1:0]   rot_valid;
        logic              any_valid;
        int                first_off;
        int                grant_sum;

        grant_en  = rst_n && !flush && !hold_valid_q && (!inflight_q || rsp_ready);
        dbl_valid = {req_valid, req_valid} >> (int'(rr_ptr_q) + 1);
        rot_valid = dbl_valid[NREQ-1:0];

        any_valid = 1'b0;
        first_off = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_valid[j]) begin
                any_valid = 1'b1;
                first_off = j;
            end
        end

        // rr_ptr+1+offset never exceeds 2*NREQ-1, so one wrap is enough
        grant_sum = int'(rr_ptr_q) + 1 + first_off;
        if (grant_sum >= NREQ) begin
            grant_sum = grant_sum - NREQ;
        end

        grant_idx = grant_sum[IDW-1:0];
        grant_vld = grant_en && any_valid;
    end

    // ------------------------------------------------------------------------
    // Grant decode and comparator operand mux. With no grant the comparator
    // sees all-zero inputs, and its result next cycle is ignored because
    // inflight will be clear.
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        cmp_a     = '0;
        cmp_b     = '0;
        cmp_func  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vld && (grant_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
                cmp_a        = req_a[i*32 +: 32];
                cmp_b        = req_b[i*32 +: 32];
                cmp_func     = req_func[i*3 +: 3];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic.
    // inflight marks that the comparator output this cycle belongs to a real
    // request. The hold buffer captures that output when the consumer stalls.
    // A new grant is blocked while the buffer is occupied, so capture and
    // release can never collide.
    // ------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        inflight_d    = grant_vld;
        inflight_id_d = inflight_id_q;
        hold_valid_d  = hold_valid_q;
        hold_id_d     = hold_id_q;
        hold_result_d = hold_result_q;

        if (grant_vld) begin
            rr_ptr_d      = grant_idx;
            inflight_id_d = grant_idx;
        end

        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (inflight_q && !rsp_ready) begin
            hold_valid_d  = 1'b1;
            hold_id_d     = inflight_id_q;
            hold_result_d = cmp_result;
        end else if (hold_valid_q && rsp_ready) begin
            hold_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. rr_ptr resets to NREQ-1 so requester 0 has first
    // priority after reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= IDW'(NREQ - 1);
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
            hold_valid_q  <= 1'b0;
            hold_id_q     <= '0;
            hold_result_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            hold_valid_q  <= hold_valid_d;
            hold_id_q     <= hold_id_d;
            hold_result_q <= hold_result_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response mux. A held result takes precedence over the live comparator
    // output.
    // ------------------------------------------------------------------------
    assign rsp_valid  = hold_valid_q || inflight_q;
    assign rsp_id     = hold_valid_q ? hold_id_q     : inflight_id_q;
    assign rsp_result = hold_valid_q ? hold_result_q : cmp_result;

endmodule

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
// tb_cmp_arbiter
// ----------------------------------------------------------------------------
// Testbench for cmp_arbiter with NREQ=3. A registered comparator stand-in
// feeds cmp_result. The reference model describes the arbiter as a single
// "pending response" with an age, a last-granted index and a comparison
// function applied directly to the requester's fields.
// ============================================================================
module tb_cmp_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int VW   = NREQ + 1 + IDW + 1 + 32 + 32 + 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ*3-1:0]   req_func;
    logic                flush;
    logic [31:0]         cmp_a;
    logic [31:0]         cmp_b;
    logic [2:0]          cmp_func;
    logic                cmp_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_result;

    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];
    logic [2:0]  f_arr [NREQ];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_pend;
    int m_age;
    int m_id;
    bit m_res;
    int m_last;

    cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .flush      (flush),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_func   (cmp_func),
        .cmp_result (cmp_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32]  = a_arr[i];
            req_b[i*32 +: 32]  = b_arr[i];
            req_func[i*3 +: 3] = f_arr[i];
        end
    end

    function automatic bit ref_cmp(logic [31:0] a, logic [31:0] b, logic [2:0] f);
        bit r;
        if (f[2]) r = f[1] ? (a < b) : ($signed(a) < $signed(b));
        else      r = (a == b);
        return r ^ f[0];
    endfunction

    // Registered comparator stand-in: result appears one cycle after issue
    always @(posedge clk) cmp_result <= ref_cmp(cmp_a, cmp_b, cmp_func);

    // Expected grant index for the current inputs, -1 for none
    function automatic int exp_grant();
        if (!rst_n || flush) return -1;
        if (m_pend && !(m_age == 1 && rsp_ready)) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        bit show;
        show = m_pend && !flush;
        return {req_ready, rsp_valid, show ? rsp_id : IDW'(0), show ? rsp_result : 1'b0,
                cmp_a, cmp_b, cmp_func};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int              g;
        bit              show;
        logic [NREQ-1:0] rr;
        logic [31:0]     ea, eb;
        logic [2:0]      ef;
        g    = exp_grant();
        show = m_pend && !flush;
        rr   = '0;
        ea   = '0;
        eb   = '0;
        ef   = '0;
        if (g >= 0) begin
            rr = NREQ'(1) << g;
            ea = a_arr[g];
            eb = b_arr[g];
            ef = f_arr[g];
        end
        return {rr, m_pend, show ? IDW'(m_id) : IDW'(0), show ? m_res : 1'b0, ea, eb, ef};
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_age  = 0;
        m_id   = 0;
        m_res  = 1'b0;
        m_last = NREQ - 1;
    endtask

    // Advance the model across one clock edge with the inputs now applied
    task automatic model_step();
        int g;
        bit r;
        g = exp_grant();
        r = 1'b0;
        if (g >= 0) r = ref_cmp(a_arr[g], b_arr[g], f_arr[g]);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (flush)                    m_pend = 1'b0;
            else if (m_pend && rsp_ready) m_pend = 1'b0;
            else if (m_pend)              m_age++;
            if (g >= 0) begin
                m_pend = 1'b1;
                m_age  = 1;
                m_id   = g;
                m_res  = r;
                m_last = g;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields(int i);
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0:       a_arr[i] = 32'hFFFF_FFFF;
            1:       a_arr[i] = 32'h8000_0000;
            2:       a_arr[i] = 32'd1;
            default: a_arr[i] = $urandom;
        endcase
        b_arr[i] = ($urandom_range(0, 3) == 0) ? a_arr[i] :
                   ($urandom_range(0, 1) == 0) ? 32'd1 : 32'($urandom);
        f_arr[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        req_valid = '1;
        @(negedge clk);
        if (req_ready !== '0) begin
            failures++;
            $display("[TB] FAIL reset_req_ready got=%b exp=000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
        end
        checks++;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        a_arr[0]  = 32'd5;
        b_arr[0]  = 32'd7;
        f_arr[0]  = 3'b100;
        req_valid = 3'b001;
        @(negedge clk);
        if (req_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL single_grant got=%b exp=001", req_ready);
        end
        checks++;
        tick();
        req_valid = '0;
        @(negedge clk);
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, IDW'(0), 1'b1}) begin
            failures++;
            $display("[TB] FAIL single_rsp got v=%b id=%0d r=%b exp v=1 id=0 r=1",
                     rsp_valid, rsp_id, rsp_result);
        end
        checks++;
        tick();
    endtask

    task automatic test_alternate();
        a_arr[0]  = 32'hFFFF_FFFF; b_arr[0] = 32'd1; f_arr[0] = 3'b100;
        a_arr[1]  = 32'hFFFF_FFFF; b_arr[1] = 32'd1; f_arr[1] = 3'b110;
        req_valid = 3'b011;
        for (int c = 0; c < 6; c++) begin
            logic [NREQ-1:0] want;
            @(negedge clk);
            want = (c % 2 == 0) ? 3'b010 : 3'b001;
            if (req_ready !== want) begin
                failures++;
                $display("[TB] FAIL alt_grant cyc=%0d got=%b exp=%b", c, req_ready, want);
            end
            checks++;
            if (c > 0) begin
                logic want_res;
                want_res = (c % 2 == 0) ? 1'b1 : 1'b0;
                if ({rsp_valid, rsp_result} !== {1'b1, want_res}) begin
                    failures++;
                    $display("[TB] FAIL alt_rsp cyc=%0d got v=%b r=%b exp v=1 r=%b",
                             c, rsp_valid, rsp_result, want_res);
                end
                checks++;
            end
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL alt_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        a_arr[1]  = 32'd9; b_arr[1] = 32'd9; f_arr[1] = 3'b000;
        a_arr[0]  = 32'd3; b_arr[0] = 32'd4; f_arr[0] = 3'b110;
        req_valid = 3'b010;
        rsp_ready = 1'b0;
        @(negedge clk);
        if (req_ready !== 3'b010) begin
            failures++;
            $display("[TB] FAIL bp_grant got=%b exp=010", req_ready);
        end
        checks++;
        tick();
        req_valid = 3'b001;
        for (int c = 1; c <= 5; c++) begin
            rsp_ready = (c >= 4);
            @(negedge clk);
            if (c <= 4) begin
                if ({req_ready, rsp_valid, rsp_id, rsp_result} !== {3'b000, 1'b1, IDW'(1), 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL bp_hold cyc=%0d got rdy=%b v=%b id=%0d r=%b exp rdy=000 v=1 id=1 r=1",
                             c, req_ready, rsp_valid, rsp_id, rsp_result);
                end
            end else begin
                if ({req_ready, rsp_valid} !== {3'b001, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL bp_resume got rdy=%b v=%b exp rdy=001 v=0",
                             req_ready, rsp_valid);
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL bp_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            tick();
        end
        drain();
    endtask

    task automatic test_toggle();
        int g;
        req_valid = 3'b011;
        for (int c = 0; c < 16; c++) begin
            rsp_ready = (c % 2 == 0);
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL toggle_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            g = exp_grant();
            tick();
            if (g >= 0) rand_fields(g);
        end
        drain();
    endtask

    task automatic test_flush();
        a_arr[0]  = 32'd2; b_arr[0] = 32'd2; f_arr[0] = 3'b000;
        req_valid = 3'b001;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            flush = (c == 1);
            @(negedge clk);
            if (c == 1 && req_ready !== 3'b000) begin
                failures++;
                $display("[TB] FAIL flush_nogrant got=%b exp=000", req_ready);
            end
            if (c == 2 && {rsp_valid, req_ready} !== {1'b0, 3'b001}) begin
                failures++;
                $display("[TB] FAIL flush_after got v=%b rdy=%b exp v=0 rdy=001",
                         rsp_valid, req_ready);
            end
            if (c == 1 || c == 2) checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL flush_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            tick();
        end
        flush = 1'b0;
        drain();
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < NREQ; i++) rand_fields(i);
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL random_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            g = exp_grant();
            tick();
            if (g >= 0) rand_fields(g);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        a_arr[0]  = 32'd1; b_arr[0] = 32'd0; f_arr[0] = 3'b100;
        req_valid = 3'b001;
        rsp_ready = 1'b0;
        tick();
        req_valid = 3'b000;
        tick();
        @(negedge clk);
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_held got=%b exp=1", rsp_valid);
        end
        checks++;
        req_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if ({rsp_valid, req_ready} !== {1'b0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL rstmid_clear got v=%b rdy=%b exp v=0 rdy=000", rsp_valid, req_ready);
        end
        checks++;
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        if (req_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL rstmid_first got=%b exp=001", req_ready);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL rstmid_vec got=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        tick();
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
            f_arr[i] = '0;
        end
        model_reset();
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_toggle();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
